spi_cmd_sequencer: RTL and testbench

- System-clock controller that sits behind the SPI byte receiver and sequences the register-access frames arriving over SPI.
- Consumes synchronized byte strobes and decodes a command/length/data frame.
- Drives a register-file write port and reads data back for the response byte path.
- Tracks frame completion and sticky protocol errors for status readout.

---
 rtl/spi_cmd_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: system-clock sequencer for SPI register-access frames.
// A frame is a command byte (rw + start address), a length byte N and N data
// bytes. Writes go to the register-file write port with an echo on tx. Reads
// prefetch register data into the transmitter two cycles after each trigger
// byte. Sticky error flags and a completed-frame counter are kept for status.
// Optional build macro: SPI_SEQ_TIMEOUT_EN adds an inter-byte timeout in
// LEN/DATA that raises err_timeout and forces the frame into DONE.
module spi_cmd_sequencer #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs_n,
  input  logic              rx_valid,
  input  logic [WIDTH-1:0]  rx_byte,
  input  logic [WIDTH-1:0]  reg_rd_data,
  output logic [WIDTH-1:0]  tx_byte,
  output logic              tx_load,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [WIDTH-1:0]  reg_wr_data,
  input  logic              err_clr,
  output logic              err_short,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic [7:0]        frame_count,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_DATA,
    S_DONE
  } state_t;

  state_t           state;
  state_t           byte_state;
  logic             rw;
  logic [WIDTH-1:0] remaining;
  logic             fetch_p1;
  logic             timeout_hit;

  assign busy = (state != S_IDLE);

  // Stage 0: state the frame would be in once the current byte is consumed
  always_comb begin
    byte_state = state;
    if (rx_valid) begin
      case (state)
        S_CMD:   byte_state = S_LEN;
        S_LEN:   byte_state = (rx_byte == '0) ? S_DONE : S_DATA;
        S_DATA:  byte_state = (remaining == WIDTH'(1)) ? S_DONE : S_DATA;
        default: byte_state = state;
      endcase
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_hit = ((state == S_LEN) || (state == S_DATA)) && !rx_valid && !cs_n &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Stage 0: idle-cycle counter between bytes, plus the sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (((state == S_LEN) || (state == S_DATA)) && !rx_valid) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
      if (err_clr) begin
        err_timeout <= 1'b0;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Stage 1: frame FSM, register port, tx path, errors and frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rw          <= 1'b0;
      remaining   <= '0;
      fetch_p1    <= 1'b0;
      tx_byte     <= '0;
      tx_load     <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_addr    <= '0;
      reg_wr_data <= '0;
      err_short   <= 1'b0;
      err_overrun <= 1'b0;
      frame_count <= '0;
    end else begin
      tx_load   <= 1'b0;
      reg_wr_en <= 1'b0;
      fetch_p1  <= 1'b0;

      // Address advances only after the write strobe has presented it
      if (reg_wr_en) begin
        reg_addr <= reg_addr + 1'b1;
      end

      // Prefetched read data goes out unless the frame has just ended
      if (fetch_p1 && !cs_n) begin
        tx_byte <= reg_rd_data;
        tx_load <= 1'b1;
      end

      if (err_clr) begin
        err_short   <= 1'b0;
        err_overrun <= 1'b0;
      end

      if (rx_valid) begin
        case (state)
          S_CMD: begin
            rw       <= rx_byte[WIDTH-1];
            reg_addr <= rx_byte[ADDR_W-1:0];
            tx_byte  <= rx_byte;
            tx_load  <= 1'b1;
          end
          S_LEN: begin
            remaining <= rx_byte;
            if (rw && (rx_byte != '0) && !cs_n) begin
              fetch_p1 <= 1'b1;
            end
          end
          S_DATA: begin
            remaining <= remaining - 1'b1;
            if (rw) begin
              reg_addr <= reg_addr + 1'b1;
              if ((remaining > WIDTH'(1)) && !cs_n) begin
                fetch_p1 <= 1'b1;
              end
            end else begin
              reg_wr_en   <= 1'b1;
              reg_wr_data <= rx_byte;
              tx_byte     <= rx_byte;
              tx_load     <= 1'b1;
            end
          end
          S_DONE: begin
            err_overrun <= 1'b1;
          end
          default: begin
          end
        endcase
      end

      if (state == S_IDLE) begin
        if (!cs_n) begin
          state <= S_CMD;
        end
      end else if (cs_n) begin
        state <= S_IDLE;
        if (byte_state == S_DONE) begin
          frame_count <= frame_count + 1'b1;
        end else if ((byte_state == S_LEN) || (byte_state == S_DATA)) begin
          err_short <= 1'b1;
        end
      end else if (timeout_hit) begin
        state <= S_DONE;
      end else begin
        state <= byte_state;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a small register-file model.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [7:0] reg_rd_data;
  logic [7:0] tx_byte;
  logic       tx_load;
  logic       reg_wr_en;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       err_clr;
  logic       err_short;
  logic       err_overrun;
  logic       err_timeout;
  logic [7:0] frame_count;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] regs [16];
  int         wr_cnt = 0;
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;

  always #5 clk = ~clk;

  spi_cmd_sequencer #(
    .WIDTH      (8),
    .ADDR_W     (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cs_n       (cs_n),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .reg_rd_data(reg_rd_data),
    .tx_byte    (tx_byte),
    .tx_load    (tx_load),
    .reg_wr_en  (reg_wr_en),
    .reg_addr   (reg_addr),
    .reg_wr_data(reg_wr_data),
    .err_clr    (err_clr),
    .err_short  (err_short),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .frame_count(frame_count),
    .busy       (busy)
  );

  assign reg_rd_data = regs[reg_addr];

  always @(posedge clk) begin
    if (reg_wr_en) begin
      regs[reg_addr] <= reg_wr_data;
      wr_cnt <= wr_cnt + 1;
    end else if (pl_en) begin
      regs[pl_addr] <= pl_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_frame_3_aa_55(input string pfx, input int fc_exp);
    int wr0;
    wr0  = wr_cnt;
    cs_n = 1'b0;
    tick();
    send_byte(8'h03);
    chk({pfx, "_cmd_txload"}, 16'(tx_load), 16'h1);
    chk({pfx, "_cmd_txbyte"}, 16'(tx_byte), 16'h03);
    chk({pfx, "_cmd_addr"}, 16'(reg_addr), 16'h3);
    tick();
    send_byte(8'h02);
    chk({pfx, "_len_txload"}, 16'(tx_load), 16'h0);
    tick();
    send_byte(8'hAA);
    chk({pfx, "_d0_wren"}, 16'(reg_wr_en), 16'h1);
    chk({pfx, "_d0_addr"}, 16'(reg_addr), 16'h3);
    chk({pfx, "_d0_wdata"}, 16'(reg_wr_data), 16'hAA);
    chk({pfx, "_d0_tx"}, {7'd0, tx_load, tx_byte}, 16'h01AA);
    tick();
    chk({pfx, "_d0_addr_inc"}, 16'(reg_addr), 16'h4);
    send_byte(8'h55);
    chk({pfx, "_d1_wren"}, 16'(reg_wr_en), 16'h1);
    chk({pfx, "_d1_addr"}, 16'(reg_addr), 16'h4);
    chk({pfx, "_d1_tx"}, {7'd0, tx_load, tx_byte}, 16'h0155);
    tick();
    cs_n = 1'b1;
    tick();
    chk({pfx, "_fcount"}, 16'(frame_count), 16'(fc_exp));
    chk({pfx, "_busy"}, 16'(busy), 16'h0);
    chk({pfx, "_errs"}, {13'd0, err_short, err_overrun, err_timeout}, 16'h0);
    chk({pfx, "_wr_cnt"}, 16'(wr_cnt - wr0), 16'h2);
    chk({pfx, "_reg3"}, 16'(regs[3]), 16'hAA);
    chk({pfx, "_reg4"}, 16'(regs[4]), 16'h55);
  endtask

  initial begin
    int wr0;
    rst      = 1'b1;
    cs_n     = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    err_clr  = 1'b0;
    pl_en    = 1'b0;
    pl_addr  = 4'h0;
    pl_data  = 8'h00;
    tick();
    tick();
    chk("rst_outputs", {tx_byte, 1'b0, tx_load, reg_wr_en, busy, reg_addr}, 16'h0);
    chk("rst_wdata_fc", {reg_wr_data, frame_count}, 16'h0);
    chk("rst_errs", {13'd0, err_short, err_overrun, err_timeout}, 16'h0);
    rst = 1'b0;
    tick();

    // Write frame
    write_frame_3_aa_55("wr", 1);

    // Read frame with address wrap 15 -> 0
    preload(4'hE, 8'h11);
    preload(4'hF, 8'h22);
    preload(4'h0, 8'h33);
    wr0  = wr_cnt;
    cs_n = 1'b0;
    tick();
    chk("rd_busy", 16'(busy), 16'h1);
    send_byte(8'h8E);
    chk("rd_cmd_tx", {7'd0, tx_load, tx_byte}, 16'h018E);
    chk("rd_cmd_addr", 16'(reg_addr), 16'hE);
    tick();
    send_byte(8'h03);
    chk("rd_len_t1", 16'(tx_load), 16'h0);
    tick();
    chk("rd_f0_t2", {7'd0, tx_load, tx_byte}, 16'h0111);
    send_byte(8'h00);
    chk("rd_d0_addr", 16'(reg_addr), 16'hF);
    chk("rd_d0_t1", 16'(tx_load), 16'h0);
    tick();
    chk("rd_f1_t2", {7'd0, tx_load, tx_byte}, 16'h0122);
    send_byte(8'h00);
    chk("rd_d1_addr_wrap", 16'(reg_addr), 16'h0);
    tick();
    chk("rd_f2_t2", {7'd0, tx_load, tx_byte}, 16'h0133);
    send_byte(8'h00);
    tick();
    chk("rd_last_no_tx", 16'(tx_load), 16'h0);
    chk("rd_done_busy", 16'(busy), 16'h1);
    cs_n = 1'b1;
    tick();
    chk("rd_fcount", 16'(frame_count), 16'h2);
    chk("rd_no_writes", 16'(wr_cnt - wr0), 16'h0);

    // Short frame
    cs_n = 1'b0;
    tick();
    send_byte(8'h01);
    tick();
    send_byte(8'h04);
    tick();
    send_byte(8'h77);
    chk("sh_write", {reg_wr_en, 3'd0, reg_addr, reg_wr_data}, 16'h8177);
    tick();
    cs_n = 1'b1;
    tick();
    chk("sh_err_short", 16'(err_short), 16'h1);
    chk("sh_fcount", 16'(frame_count), 16'h2);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("sh_err_clr", 16'(err_short), 16'h0);

    // Last byte coincides with cs_n rising
    cs_n = 1'b0;
    tick();
    send_byte(8'h02);
    tick();
    send_byte(8'h01);
    tick();
    rx_byte  = 8'h99;
    rx_valid = 1'b1;
    cs_n     = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("sim_write", {reg_wr_en, 3'd0, reg_addr, reg_wr_data}, 16'h8299);
    chk("sim_tx", {7'd0, tx_load, tx_byte}, 16'h0199);
    chk("sim_fcount", 16'(frame_count), 16'h3);
    chk("sim_no_short", {err_short, busy}, 16'h0);
    tick();

    // Overrun in DONE
    wr0  = wr_cnt;
    cs_n = 1'b0;
    tick();
    send_byte(8'h02);
    tick();
    send_byte(8'h00);
    tick();
    chk("ov_pre", 16'(err_overrun), 16'h0);
    send_byte(8'h44);
    chk("ov_flag", 16'(err_overrun), 16'h1);
    chk("ov_no_wr_tx", {reg_wr_en, tx_load}, 16'h0);
    tick();
    cs_n = 1'b1;
    tick();
    chk("ov_no_writes", 16'(wr_cnt - wr0), 16'h0);
    chk("ov_fcount", 16'(frame_count), 16'h4);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ov_clr", 16'(err_overrun), 16'h0);

    // Reset in the middle of DATA
    cs_n = 1'b0;
    tick();
    send_byte(8'h05);
    tick();
    send_byte(8'h03);
    tick();
    send_byte(8'h12);
    chk("mr_pre_wr", 16'(reg_wr_en), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_outputs", {tx_byte, 1'b0, tx_load, reg_wr_en, busy, reg_addr}, 16'h0);
    chk("mr_wdata_fc", {reg_wr_data, frame_count}, 16'h0);
    cs_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    write_frame_3_aa_55("pr", 1);

    // Inter-byte timeout
    cs_n = 1'b0;
    tick();
    send_byte(8'h00);
    tick();
    send_byte(8'h02);
    repeat (15) tick();
    chk("to_before", 16'(err_timeout), 16'h0);
    tick();
`ifdef SPI_SEQ_TIMEOUT_EN
    chk("to_flag", 16'(err_timeout), 16'h1);
    send_byte(8'h66);
    chk("to_done_overrun", {err_overrun, reg_wr_en}, 16'h2);
`else
    chk("to_flag_off", 16'(err_timeout), 16'h0);
    send_byte(8'h66);
    chk("to_still_data", {err_overrun, reg_wr_en}, 16'h1);
`endif
    tick();
    cs_n = 1'b1;
    tick();
    chk("to_idle", 16'(busy), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
